// File: rtl/axi_sram_arbiter.sv
// axi_sram_arbiter
// Shares one AXI3-style master port between the instruction-fetch port
// (read only) and the data-memory port (read/write). One transaction is in
// flight at a time. Every access walks an explicit FSM:
//   read : IDLE -> AR -> R -> DONE
//   write: IDLE -> AW -> B -> DONE   (W is issued alongside AW)
// DONE raises a one-cycle completion pulse to the requester that owned the
// transaction.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   inst_*            fetch request/response (en held until inst_valid)
//   data_*            load/store request/response (en held until data_valid;
//                     data_wen == 0 means read)
//   busy              high whenever the FSM is not in IDLE
//   dbg_state_o       current FSM state (encoding of state_e)
//   ar*/r*            AXI read address / read data channels
//   aw*/w*/b*         AXI write address / write data / write response
//
// Handshake rule: a transfer happens on a rising edge where VALID and READY
// are both high. Our VALIDs rise on entry to their state, never drop before
// that transfer, and drop on the edge where it happens. Address, id, data and
// strobe outputs come from registers loaded only at grant, so they stay put
// until the next grant.
module axi_sram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // fetch port
  input  logic                inst_en,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_valid,
  // data port
  input  logic                data_en,
  input  logic [3:0]          data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_valid,
  // status
  output logic                busy,
  output logic [2:0]          dbg_state_o,
  // AXI read address
  output logic [3:0]          arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [3:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  // AXI read data
  input  logic [3:0]          rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  // AXI write address
  output logic [3:0]          awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [3:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  // AXI write data
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  // AXI write response
  input  logic [3:0]          bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW   = 3'd3,
    S_B    = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic                last_data_q;   // 1: previous grant went to the data port
  logic                gnt_data_q;    // owner of the current transaction
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic                inst_valid_q, data_valid_q;
  logic [DATA_W-1:0]   inst_rdata_q, data_rdata_q;

  logic                grant_data, grant_inst, grant_write;
  logic                aw_done, w_done;

  // Response id/status fields carry nothing this master acts on.
  logic                unused_resp;
  assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

  always_comb begin
    // Data wins a tie unless it also won the previous grant.
    grant_data  = data_en && !(inst_en && last_data_q);
    grant_inst  = inst_en && !grant_data;
    grant_write = grant_data && (data_wen != 4'b0000);
    // AW and W complete independently; a channel counts as done once its
    // valid has dropped or it handshakes this cycle.
    aw_done     = !awvalid_q || awready;
    w_done      = !wvalid_q  || wready;

    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_write)                    state_d = S_AW;
        else if (grant_data || grant_inst)  state_d = S_AR;
      end
      S_AR:   if (arready)           state_d = S_R;
      S_R:    if (rvalid)            state_d = S_DONE;
      S_AW:   if (aw_done && w_done) state_d = S_B;
      S_B:    if (bvalid)            state_d = S_DONE;
      S_DONE:                        state_d = S_IDLE;
      default:                       state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_data_q  <= 1'b0;
      gnt_data_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (grant_data || grant_inst) begin
            addr_q      <= grant_data ? data_addr : inst_addr;
            wdata_q     <= data_wdata;
            wstrb_q     <= grant_write ? STRB_W'(data_wen) : '0;
            gnt_data_q  <= grant_data;
            last_data_q <= grant_data;
            if (grant_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              arvalid_q <= 1'b1;
            end
          end
        end
        S_AR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        S_R: begin
          if (rvalid) begin
            rready_q <= 1'b0;
            if (gnt_data_q) data_rdata_q <= rdata;
            else            inst_rdata_q <= rdata;
            data_valid_q <= gnt_data_q;
            inst_valid_q <= !gnt_data_q;
          end
        end
        S_AW: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) bready_q <= 1'b1;
        end
        S_B: begin
          if (bvalid) begin
            bready_q     <= 1'b0;
            data_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

  assign inst_rdata  = inst_rdata_q;
  assign inst_valid  = inst_valid_q;
  assign data_rdata  = data_rdata_q;
  assign data_valid  = data_valid_q;

  // Fetch reads use id 0, data reads id 1; writes always come from data.
  assign arid    = {3'b000, gnt_data_q};
  assign araddr  = addr_q;
  assign arlen   = 4'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign awid    = 4'd1;
  assign awaddr  = addr_q;
  assign awlen   = 4'd0;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awvalid = awvalid_q;

  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

endmodule

// File: doc/axi_sram_arbiter.md
Name: axi_sram_arbiter

Overview:
- Single-outstanding AXI master that shares one AXI3-style port between the instruction fetch (read-only) and the data memory stage (read/write).
- Sits between the CPU pipeline and the SoC crossbar.
- Sequences every access through an explicit AR/R or AW/W/B handshake FSM.
- Returns a one-cycle completion pulse per requester; the pipeline stalls on it.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (wstrb width = DATA_W/8)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- inst_en  in  1  fetch request; held until inst_valid
- inst_addr  in  ADDR_W  fetch address; stable while inst_en is high
- inst_rdata  out  DATA_W  fetched word; valid with inst_valid
- inst_valid  out  1  one-cycle completion pulse
- data_en  in  1  data request; held until data_valid
- data_wen  in  4  byte write enables; 0 means read
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data
- data_rdata  out  DATA_W  load data; valid with data_valid
- data_valid  out  1  one-cycle completion pulse (reads and writes)
- busy  out  1  high whenever state is not IDLE
- arid, araddr, arlen[3:0], arsize[2:0], arburst[1:0], arvalid  out  AXI read address channel
- arready  in  1
- rid[3:0], rdata, rresp[1:0], rlast, rvalid  in  AXI read data channel
- rready  out  1
- awid, awaddr, awlen, awsize, awburst, awvalid  out  AXI write address channel
- awready  in  1
- wdata, wstrb, wlast, wvalid  out  AXI write data channel
- wready  in  1
- bid[3:0], bresp[1:0], bvalid  in  AXI write response channel
- bready  out  1

Behaviour:
- Reset is asynchronous and active-high: state=IDLE, last_grant=INST, all valid/ready outputs 0, rdata registers 0, address/data registers 0. A reset mid-transaction abandons the transaction; no completion pulse is produced.
- Constants: arlen=awlen=0, arsize=awsize=3'b010, arburst=awburst=2'b01, wlast=1. arid=0 for fetch and 1 for data reads; awid=1.
- States: IDLE, AR, R, AW, B, DONE.
- IDLE arbitration:
  - Only one requester high: grant it.
  - Both high: grant data, unless last_grant=DATA, in which case grant inst (anti-starvation).
  - On grant, register the address, wdata and wstrb, and the requester ID. Update last_grant.
  - Next state is AW if the grant is data with data_wen!=0; otherwise AR.
- AR: arvalid=1, araddr from register. On arready go to R.
- R: rready=1. On rvalid, capture rdata into the granted requester's rdata register and go to DONE. rresp/rid/rlast are ignored.
- AW:
  - awvalid and wvalid both assert on entry.
  - Each drops independently after its own handshake (awvalid&awready, wvalid&wready). Handshakes may occur in either order or the same cycle.
  - When both are complete, go to B.
- B: bready=1. On bvalid go to DONE. bresp is ignored.
- DONE: the granted requester's *_valid=1 for exactly this cycle, then IDLE. No arbitration in DONE, so a request still held this cycle is not re-granted.
- Latency, zero-wait slave: read is 4 cycles from grant cycle to valid pulse (IDLE→AR→R→DONE); write is also 4 (IDLE→AW→B→DONE).
- AXI valid signals never drop before their handshake. Address and data outputs stay constant from grant until the next grant.
- Requests that drop before completion are a protocol violation; the transaction completes anyway.

Test Plan:
- Fetch only: inst_en=1, addr=0xBFC00000, slave returns 0x3C08BFC0 with zero wait → araddr=0xBFC00000, arid=0; inst_valid pulses once in cycle 4 with inst_rdata=0x3C08BFC0.
- Store: data_en=1, wen=4'b0011, addr=0x80001000, wdata=0xDEADBEEF; wready 2 cycles after awready → wstrb=0011, awid=1; data_valid pulses once after bvalid; no AR activity.
- Contention: inst and data both held continuously → grants alternate data, inst, data, inst; each completion pulse occurs exactly once per transaction.
- Backpressure: arready low 5 cycles, rvalid delayed 3 → araddr/arvalid stable throughout, rready stays high, busy=1 until DONE.
- Write handshake ordering: wready before awready, then the same cycle → wvalid drops first; state reaches B only after both handshakes.
- Reset asserted in R state with rvalid pending → all outputs reset immediately (asynchronously); no valid pulse; the next inst_en restarts from IDLE.
